// File: rtl/rvfi_pc_window_pkg.sv
// Shared types and helpers for the RVFI PC window checker.
package rvfi_pc_window_pkg;

  localparam int ORDER_W = 64;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2,
    ST_FAIL  = 2'd3
  } state_e;

  // Operands are zero-extended to 128 bits so one function serves any XLEN.
  function automatic logic addr_eq(input logic [127:0] a, input logic [127:0] b,
                                   input int align_lsb);
    logic [127:0] mask;
    mask = {128{1'b1}} << align_lsb;
    return (a & mask) == (b & mask);
  endfunction

endpackage

// File: rtl/rvfi_pc_window_entry.sv
// One window slot: catches the retirement whose order maps to IDX and flags duplicates.
module rvfi_pc_window_entry
  import rvfi_pc_window_pkg::*;
#(
  parameter int NRET        = 1,
  parameter int XLEN        = 32,
  parameter int IDX         = 0,
  parameter bit STORE_WDATA = 1'b1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    wr_en,
  input  logic [ORDER_W-1:0]      base,
  input  logic [NRET-1:0]         rvfi_valid,
  input  logic [ORDER_W*NRET-1:0] rvfi_order,
  input  logic [XLEN*NRET-1:0]    rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]    rvfi_pc_wdata,
  output logic                    valid_nxt,
  output logic [XLEN-1:0]         rdata_nxt,
  output logic [XLEN-1:0]         wdata_nxt,
  output logic                    dup
);

  localparam logic [ORDER_W-1:0] IDX_W = ORDER_W'(IDX);

  logic            valid_q;
  logic [XLEN-1:0] rdata_q;
  logic [XLEN-1:0] wdata_q;
  logic            hit_any;
  logic            hit_multi;
  logic            valid_base;
  logic [XLEN-1:0] sel_r;
  logic [XLEN-1:0] sel_w;

  // Lowest-numbered matching channel owns the write; any second match is a duplicate.
  always_comb begin
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    sel_r     = '0;
    sel_w     = '0;
    for (int c = 0; c < NRET; c++) begin
      if (wr_en && rvfi_valid[c] &&
          ((rvfi_order[c*ORDER_W +: ORDER_W] - base) == IDX_W)) begin
        if (hit_any) begin
          hit_multi = 1'b1;
        end else begin
          sel_r = rvfi_pc_rdata[c*XLEN +: XLEN];
          sel_w = rvfi_pc_wdata[c*XLEN +: XLEN];
        end
        hit_any = 1'b1;
      end
    end
    valid_base = clear ? 1'b0 : valid_q;
    valid_nxt  = valid_base | hit_any;
    rdata_nxt  = hit_any ? sel_r : rdata_q;
    wdata_nxt  = (STORE_WDATA && hit_any) ? sel_w : wdata_q;
    dup        = hit_multi || (hit_any && valid_base);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      rdata_q <= '0;
      wdata_q <= '0;
    end else begin
      valid_q <= valid_nxt;
      rdata_q <= rdata_nxt;
      wdata_q <= wdata_nxt;
    end
  end

endmodule

// File: rtl/rvfi_pc_window_check.sv
// Checks pc_wdata(k) == pc_rdata(k+1) over DEPTH consecutive retire orders from a base.
// state | meaning
// IDLE  | no window armed since reset
// ARMED | collecting retirements and comparing completed pairs
// DONE  | all DEPTH pairs matched; table frozen
// FAIL  | first mismatch or duplicate latched; table frozen
module rvfi_pc_window_check
  import rvfi_pc_window_pkg::*;
#(
  parameter int NRET      = 1,
  parameter int XLEN      = 32,
  parameter int DEPTH     = 8,
  parameter int ALIGN_LSB = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  input  logic [ORDER_W-1:0]           base_order,
  input  logic [NRET-1:0]              rvfi_valid,
  input  logic [ORDER_W*NRET-1:0]      rvfi_order,
  input  logic [XLEN*NRET-1:0]         rvfi_pc_rdata,
  input  logic [XLEN*NRET-1:0]         rvfi_pc_wdata,
  output logic                         busy,
  output logic                         done,
  output logic                         fail,
  output logic                         dup_err,
  output logic [ORDER_W-1:0]           err_order,
  output logic [XLEN-1:0]              err_expect,
  output logic [XLEN-1:0]              err_actual,
  output logic [$clog2(DEPTH+1)-1:0]   pairs_checked
);

  localparam int PC_W = $clog2(DEPTH+1);

  state_e             state_q;
  logic [ORDER_W-1:0] base_q;
  logic [ORDER_W-1:0] base_eff;
  logic               wr_en;
  logic [DEPTH:0]     v_nxt;
  logic [DEPTH:0]     dup_hit;
  logic [XLEN-1:0]    r_nxt [1:DEPTH];
  logic [XLEN-1:0]    w_nxt [0:DEPTH-1];
  logic [XLEN-1:0]    unused_rdata0;
  logic [XLEN-1:0]    unused_wdata;
  logic [DEPTH-1:0]   checked_q;
  logic [DEPTH-1:0]   checked_base;
  logic [DEPTH-1:0]   ready_new;
  logic [DEPTH-1:0]   mismatch;
  logic [PC_W-1:0]    pair_cnt;
  logic [PC_W-1:0]    pc_next;
  logic               err_hit;
  logic               err_is_dup;
  logic [ORDER_W-1:0] err_ord_n;
  logic [XLEN-1:0]    err_exp_n;
  logic [XLEN-1:0]    err_act_n;

  // Retirements in the start cycle index against the incoming base.
  assign base_eff = start ? base_order : base_q;
  assign wr_en    = start || (state_q == ST_ARMED);
  assign busy     = (state_q == ST_ARMED);

  for (genvar e = 0; e <= DEPTH; e++) begin : g_entry
    if (e == 0) begin : g_first
      rvfi_pc_window_entry #(.NRET(NRET), .XLEN(XLEN), .IDX(e), .STORE_WDATA(1'b1)) u_entry (
        .clock(clock), .reset(reset), .clear(start), .wr_en(wr_en), .base(base_eff),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .valid_nxt(v_nxt[e]), .rdata_nxt(unused_rdata0), .wdata_nxt(w_nxt[e]),
        .dup(dup_hit[e])
      );
    end else if (e == DEPTH) begin : g_last
      rvfi_pc_window_entry #(.NRET(NRET), .XLEN(XLEN), .IDX(e), .STORE_WDATA(1'b0)) u_entry (
        .clock(clock), .reset(reset), .clear(start), .wr_en(wr_en), .base(base_eff),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .valid_nxt(v_nxt[e]), .rdata_nxt(r_nxt[e]), .wdata_nxt(unused_wdata),
        .dup(dup_hit[e])
      );
    end else begin : g_mid
      rvfi_pc_window_entry #(.NRET(NRET), .XLEN(XLEN), .IDX(e), .STORE_WDATA(1'b1)) u_entry (
        .clock(clock), .reset(reset), .clear(start), .wr_en(wr_en), .base(base_eff),
        .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
        .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
        .valid_nxt(v_nxt[e]), .rdata_nxt(r_nxt[e]), .wdata_nxt(w_nxt[e]),
        .dup(dup_hit[e])
      );
    end
  end

  always_comb begin
    checked_base = start ? '0 : checked_q;
    ready_new    = '0;
    mismatch     = '0;
    pair_cnt     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      ready_new[i] = wr_en && v_nxt[i] && v_nxt[i+1] && !checked_base[i];
      mismatch[i]  = ready_new[i] &&
                     !addr_eq(128'(w_nxt[i]), 128'(r_nxt[i+1]), ALIGN_LSB);
      pair_cnt     = pair_cnt + PC_W'(ready_new[i]);
    end
    pc_next = (start ? '0 : pairs_checked) + pair_cnt;

    // Descending scans leave the lowest index; the duplicate scan runs last so it wins.
    err_hit    = 1'b0;
    err_is_dup = 1'b0;
    err_ord_n  = '0;
    err_exp_n  = '0;
    err_act_n  = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      if (mismatch[i]) begin
        err_hit   = 1'b1;
        err_ord_n = base_eff + ORDER_W'(i);
        err_exp_n = r_nxt[i+1];
        err_act_n = w_nxt[i];
      end
    end
    for (int e = DEPTH; e >= 0; e--) begin
      if (dup_hit[e]) begin
        err_hit    = 1'b1;
        err_is_dup = 1'b1;
        err_ord_n  = base_eff + ORDER_W'(e);
        err_exp_n  = '0;
        err_act_n  = '0;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      base_q        <= '0;
      checked_q     <= '0;
      pairs_checked <= '0;
      done          <= 1'b0;
      fail          <= 1'b0;
      dup_err       <= 1'b0;
      err_order     <= '0;
      err_expect    <= '0;
      err_actual    <= '0;
    end else begin
      if (start) begin
        base_q     <= base_order;
        done       <= 1'b0;
        fail       <= 1'b0;
        dup_err    <= 1'b0;
        err_order  <= '0;
        err_expect <= '0;
        err_actual <= '0;
      end
      if (wr_en) begin
        checked_q     <= checked_base | ready_new;
        pairs_checked <= pc_next;
        if (err_hit) begin
          state_q    <= ST_FAIL;
          fail       <= 1'b1;
          dup_err    <= err_is_dup;
          err_order  <= err_ord_n;
          err_expect <= err_exp_n;
          err_actual <= err_act_n;
        end else if (pc_next == PC_W'(DEPTH)) begin
          state_q <= ST_DONE;
          done    <= 1'b1;
        end else begin
          state_q <= ST_ARMED;
        end
      end
    end
  end

endmodule

// File: tb/tb_rvfi_pc_window_check.sv
// Scoreboard bench: each window pushes its expected final status, a monitor checks it on done/fail.
module tb_rvfi_pc_window_check;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [63:0]   base_order = '0;
  logic [1:0]    rvfi_valid = '0;
  logic [127:0]  rvfi_order = '0;
  logic [63:0]   rvfi_pc_rdata = '0;
  logic [63:0]   rvfi_pc_wdata = '0;
  logic          busy, done, fail, dup_err;
  logic [63:0]   err_order;
  logic [31:0]   err_expect, err_actual;
  logic [2:0]    pairs_checked;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic        done;
    logic        fail;
    logic        dup;
    logic [63:0] ord;
    logic [31:0] ex;
    logic [31:0] ac;
    logic [2:0]  pc;
  } exp_t;

  exp_t  sb_q[$];
  string sb_name[$];
  logic  term_q = 1'b0;

  rvfi_pc_window_check #(.NRET(2), .XLEN(32), .DEPTH(4), .ALIGN_LSB(1)) dut (
    .clock(clock), .reset(reset), .start(start), .base_order(base_order),
    .rvfi_valid(rvfi_valid), .rvfi_order(rvfi_order),
    .rvfi_pc_rdata(rvfi_pc_rdata), .rvfi_pc_wdata(rvfi_pc_wdata),
    .busy(busy), .done(done), .fail(fail), .dup_err(dup_err),
    .err_order(err_order), .err_expect(err_expect), .err_actual(err_actual),
    .pairs_checked(pairs_checked)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expect_end(input string n, input logic d, input logic f, input logic du,
                            input logic [63:0] o, input logic [31:0] ex, input logic [31:0] ac,
                            input logic [2:0] pc);
    exp_t e;
    e = '{done: d, fail: f, dup: du, ord: o, ex: ex, ac: ac, pc: pc};
    sb_q.push_back(e);
    sb_name.push_back(n);
  endtask

  // Monitor: a rising done|fail is the DUT presenting a window result.
  always @(negedge clock) begin
    if (reset) begin
      term_q <= 1'b0;
    end else begin
      if ((done || fail) && !term_q) begin
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_result", 64'(done || fail), 64'd0);
        end else begin
          exp_t  e;
          string n;
          e = sb_q.pop_front();
          n = sb_name.pop_front();
          chk({n, "_done"},       64'(done),          64'(e.done));
          chk({n, "_fail"},       64'(fail),          64'(e.fail));
          chk({n, "_dup_err"},    64'(dup_err),       64'(e.dup));
          chk({n, "_err_order"},  err_order,          e.ord);
          chk({n, "_err_expect"}, 64'(err_expect),    64'(e.ex));
          chk({n, "_err_actual"}, 64'(err_actual),    64'(e.ac));
          chk({n, "_pairs"},      64'(pairs_checked), 64'(e.pc));
          chk({n, "_busy"},       64'(busy),          64'd0);
        end
      end
      term_q <= done || fail;
    end
  end

  task automatic drive(input logic st, input logic [63:0] b, input logic [1:0] v,
                       input logic [63:0] o0, input logic [31:0] r0, input logic [31:0] w0,
                       input logic [63:0] o1, input logic [31:0] r1, input logic [31:0] w1);
    @(negedge clock);
    start         = st;
    base_order    = b;
    rvfi_valid    = v;
    rvfi_order    = {o1, o0};
    rvfi_pc_rdata = {r1, r0};
    rvfi_pc_wdata = {w1, w0};
  endtask

  task automatic ret(input logic [63:0] o, input logic [31:0] r, input logic [31:0] w);
    drive(1'b0, 64'd0, 2'b01, o, r, w, 64'd0, 32'd0, 32'd0);
  endtask

  task automatic idle();
    drive(1'b0, 64'd0, 2'b00, 64'd0, 32'd0, 32'd0, 64'd0, 32'd0, 32'd0);
  endtask

  task automatic begin_window(input logic [63:0] b);
    drive(1'b1, b, 2'b00, 64'd0, 32'd0, 32'd0, 64'd0, 32'd0, 32'd0);
  endtask

  task automatic wait_term(input string n);
    int k;
    k = 0;
    while (!(done || fail) && k < 20) begin
      idle();
      k++;
    end
    chk({n, "_terminated"}, 64'(done || fail), 64'd1);
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_busy",  64'(busy), 64'd0);
    chk("rst_done",  64'(done), 64'd0);
    chk("rst_fail",  64'(fail), 64'd0);
    chk("rst_pairs", 64'(pairs_checked), 64'd0);
    chk("rst_order", err_order, 64'd0);
    @(negedge clock);
    reset = 1'b0;
    idle();
    chk("idle_busy", 64'(busy), 64'd0);

    // In-order single-channel window.
    expect_end("s1", 1'b1, 1'b0, 1'b0, 64'd0, 32'h0, 32'h0, 3'd4);
    begin_window(64'd100);
    ret(64'd100, 32'h1000, 32'h1004);
    ret(64'd101, 32'h1004, 32'h1008);
    ret(64'd102, 32'h1008, 32'h100C);
    ret(64'd103, 32'h100C, 32'h1010);
    idle();
    chk("s1_pairs_3", 64'(pairs_checked), 64'd3);
    chk("s1_busy",    64'(busy), 64'd1);
    chk("s1_not_done_yet", 64'(done), 64'd0);
    ret(64'd104, 32'h1010, 32'h1014);
    idle();
    chk("s1_done_latency", 64'(done), 64'd1);
    wait_term("s1");

    // Swapped channels in the start cycle, then out-of-order completion of two pairs at once.
    expect_end("s2", 1'b1, 1'b0, 1'b0, 64'd0, 32'h0, 32'h0, 3'd4);
    drive(1'b1, 64'd100, 2'b11, 64'd101, 32'h2004, 32'h2008, 64'd100, 32'h2000, 32'h2004);
    idle();
    chk("s2_start_pairs", 64'(pairs_checked), 64'd1);
    chk("s2_start_busy",  64'(busy), 64'd1);
    ret(64'd103, 32'h200C, 32'h2010);
    ret(64'd102, 32'h2008, 32'h200C);
    idle();
    chk("s2_double_pairs", 64'(pairs_checked), 64'd3);
    ret(64'd104, 32'h2010, 32'h2014);
    wait_term("s2");

    // Mismatch on pair (102,103).
    expect_end("s3", 1'b0, 1'b1, 1'b0, 64'd102, 32'h200C, 32'h2008, 3'd3);
    begin_window(64'd100);
    ret(64'd100, 32'h2000, 32'h2004);
    ret(64'd101, 32'h2004, 32'h2008);
    ret(64'd102, 32'h2008, 32'h2008);
    ret(64'd103, 32'h200C, 32'h2010);
    wait_term("s3");
    ret(64'd104, 32'h2010, 32'h2014);
    idle();
    chk("s3_frozen_pairs", 64'(pairs_checked), 64'd3);
    chk("s3_frozen_done",  64'(done), 64'd0);
    chk("s3_frozen_fail",  64'(fail), 64'd1);

    // Low bit ignored, then a repeated order.
    expect_end("s4", 1'b0, 1'b1, 1'b1, 64'd101, 32'h0, 32'h0, 3'd1);
    begin_window(64'd100);
    ret(64'd100, 32'h3000, 32'h3001);
    ret(64'd101, 32'h3000, 32'h3004);
    idle();
    chk("s4_align_pairs", 64'(pairs_checked), 64'd1);
    chk("s4_align_fail",  64'(fail), 64'd0);
    ret(64'd101, 32'h3000, 32'h3004);
    wait_term("s4");

    // Same order on both channels in one cycle.
    expect_end("s5", 1'b0, 1'b1, 1'b1, 64'd102, 32'h0, 32'h0, 3'd0);
    begin_window(64'd100);
    drive(1'b0, 64'd0, 2'b11, 64'd102, 32'h5000, 32'h5004, 64'd102, 32'h5000, 32'h5004);
    wait_term("s5");

    // Window straddling 2^64, with an out-of-window order on the second channel.
    expect_end("s6", 1'b1, 1'b0, 1'b0, 64'd0, 32'h0, 32'h0, 3'd4);
    begin_window(64'hFFFF_FFFF_FFFF_FFFE);
    ret(64'hFFFF_FFFF_FFFF_FFFE, 32'h4000, 32'h4004);
    drive(1'b0, 64'd0, 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 32'h4004, 32'h4008,
          64'd10, 32'h9999, 32'h9999);
    ret(64'd0, 32'h4008, 32'h400C);
    ret(64'd1, 32'h400C, 32'h4010);
    ret(64'd2, 32'h4010, 32'h4014);
    wait_term("s6");
    ret(64'd5, 32'h7777, 32'h7777);
    ret(64'd0, 32'h4008, 32'h400C);
    idle();
    chk("s6_ignored_done", 64'(done), 64'd1);
    chk("s6_ignored_fail", 64'(fail), 64'd0);
    chk("s6_ignored_pairs", 64'(pairs_checked), 64'd4);

    // Asynchronous reset mid-window, then a fresh window at base 0.
    begin_window(64'd100);
    ret(64'd100, 32'h6000, 32'h6004);
    ret(64'd101, 32'h6004, 32'h6008);
    ret(64'd102, 32'h6008, 32'h600C);
    idle();
    chk("s7_pairs_before_reset", 64'(pairs_checked), 64'd2);
    #2 reset = 1'b1;
    #1;
    chk("s7_reset_busy",  64'(busy), 64'd0);
    chk("s7_reset_pairs", 64'(pairs_checked), 64'd0);
    chk("s7_reset_fail",  64'(fail), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    expect_end("s7", 1'b1, 1'b0, 1'b0, 64'd0, 32'h0, 32'h0, 3'd4);
    begin_window(64'd0);
    ret(64'd0, 32'h7000, 32'h7004);
    ret(64'd1, 32'h7004, 32'h7008);
    ret(64'd2, 32'h7008, 32'h700C);
    ret(64'd3, 32'h700C, 32'h7010);
    ret(64'd4, 32'h7010, 32'h7014);
    wait_term("s7");

    idle();
    chk("sb_drain", 64'(sb_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
